cc_pattern_tx: RTL and testbench

Transmitter for the CC (Candy Crush) input protocol. It accepts one packed 223-bit test pattern, serializes it onto the CC board-load (`in_valid_1`) and action (`in_valid_2`) streams, then waits for the CC response and reports the captured score and protocol errors. It sits in front of `CC` in on-chip self-test and FPGA bring-up, replacing the simulation-only stimulus.

---
 rtl/cc_pkg.sv | 40 ++++
 rtl/cc_score_mon.sv | 63 ++++++
 rtl/cc_pattern_tx.sv | 157 +++++++++++++++
 tb/tb_cc_pattern_tx.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/cc_pkg.sv
// Shared constants, FSM state and error-bit indices for the CC pattern transmitter.
package cc_pkg;

  localparam int PATTERN_BITS = 223;
  localparam int N_CELLS      = 36;
  localparam int N_ACTIONS    = 10;
  localparam int N_STRIPES    = 4;

  // Field MSBs inside the packed pattern
  localparam int COLOR_MSB = 222;
  localparam int SROW_MSB  = 114;
  localparam int SCOL_MSB  = 102;
  localparam int STYPE_MSB = 90;
  localparam int AROW_MSB  = 86;
  localparam int ACOL_MSB  = 56;
  localparam int ACT_MSB   = 26;
  localparam int SCORE_MSB = 6;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_COLOR,
    ST_GAP,
    ST_ACTION,
    ST_WAIT,
    ST_REPORT
  } state_t;

  localparam int ERR_SCORE   = 0;
  localparam int ERR_TIMEOUT = 1;
  localparam int ERR_DOUBLE  = 2;
  localparam int ERR_PROTO   = 3;

  // 3-bit field starting at bit lsb; a shift keeps the select index width-clean
  function automatic logic [2:0] fld3(input logic [PATTERN_BITS-1:0] p, input int lsb);
    logic [PATTERN_BITS-1:0] s;
    s = p >> lsb;
    return s[2:0];
  endfunction

endpackage

// File: rtl/cc_score_mon.sv
// Response checker: WAIT timeout counter, back-to-back out_valid check,
// idle-score check and score compare. Outputs are the flag values as they
// will be on the next edge, so the top can register them into the result.
module cc_score_mon
  import cc_pkg::*;
#(
  parameter int TIMEOUT = 500
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       accept,
  input  state_t     state,
  input  logic       out_valid,
  input  logic [6:0] out_score,
  input  logic [6:0] exp_score,
  output logic       done,
  output logic [6:0] score_nxt,
  output logic [3:0] err_nxt
);

  logic [9:0] tmo_q;
  logic [6:0] score_q;
  logic       ov_q, dbl_q, proto_q;
  logic       active, in_wait, hit, tmo_hit, dbl_cur, proto_cur;

  // sampling window runs from the accept cycle through REPORT
  assign active    = accept || (state != ST_IDLE);
  assign in_wait   = (state == ST_WAIT);
  assign hit       = in_wait && out_valid;
  assign tmo_hit   = in_wait && !out_valid && (tmo_q == 10'(TIMEOUT - 1));
  assign done      = hit || tmo_hit;
  assign dbl_cur   = active && out_valid && ov_q;
  assign proto_cur = active && ((!out_valid && (out_score != '0)) || (out_valid && !in_wait));
  assign score_nxt = hit ? out_score : score_q;

  // flags seen so far for this pattern plus this cycle's sample
  always_comb begin
    err_nxt              = '0;
    err_nxt[ERR_SCORE]   = hit && (out_score != exp_score);
    err_nxt[ERR_TIMEOUT] = tmo_hit;
    err_nxt[ERR_DOUBLE]  = (dbl_q && !accept) || dbl_cur;
    err_nxt[ERR_PROTO]   = (proto_q && !accept) || proto_cur;
  end

  // timeout counter, captured score and sticky protocol flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_q   <= '0;
      score_q <= '0;
      ov_q    <= 1'b0;
      dbl_q   <= 1'b0;
      proto_q <= 1'b0;
    end else begin
      tmo_q   <= in_wait ? tmo_q + 10'd1 : '0;
      ov_q    <= active && out_valid;
      dbl_q   <= active && err_nxt[ERR_DOUBLE];
      proto_q <= active && err_nxt[ERR_PROTO];
      if (accept)   score_q <= '0;
      else if (hit) score_q <= out_score;
    end
  end

endmodule

// File: rtl/cc_pattern_tx.sv
// Serializes one packed 223-bit pattern onto the CC board-load and action
// streams, then reports the CC response.
// Optional response checker: define CC_PATTERN_TX_CHECK_EN.
module cc_pattern_tx
  import cc_pkg::*;
#(
  parameter int GAP_CYCLES = 1,
  parameter int TIMEOUT    = 500
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    pat_valid,
  output logic                    pat_ready,
  input  logic [PATTERN_BITS-1:0] pat_data,
  output logic                    in_valid_1,
  output logic                    in_valid_2,
  output logic [2:0]              in_color,
  output logic [5:0]              in_starting_pos,
  output logic                    in_stripe,
  output logic [1:0]              in_action,
  input  logic                    out_valid,
  input  logic [6:0]              out_score,
  output logic                    result_valid,
  output logic [6:0]              result_score,
  output logic [3:0]              result_err,
  output logic                    result_pass
);

  state_t                  state_q, state_d;
  logic [5:0]              cnt_q, cnt_d;
  logic [PATTERN_BITS-1:0] pat_q, pat_src;
  logic                    accept, wait_done;
  logic                    v1_d, v2_d, stripe_d, rv_d;
  logic [2:0]              color_d, t3;
  logic [5:0]              pos_d;
  logic [1:0]              act_d;
  logic [6:0]              mon_score;
  logic [3:0]              mon_err;
  int                      i;

  assign accept  = pat_valid && (state_q == ST_IDLE);
  // outputs are computed from the next state, so the accept cycle reads the bus directly
  assign pat_src = accept ? pat_data : pat_q;

`ifdef CC_PATTERN_TX_CHECK_EN
  cc_score_mon #(.TIMEOUT(TIMEOUT)) u_mon (
    .clk       (clk),
    .rst_n     (rst_n),
    .accept    (accept),
    .state     (state_q),
    .out_valid (out_valid),
    .out_score (out_score),
    .exp_score (pat_q[SCORE_MSB:0]),
    .done      (wait_done),
    .score_nxt (mon_score),
    .err_nxt   (mon_err)
  );
`else
  logic unused_ok;
  assign unused_ok = ^{out_valid, out_score, pat_q[SCORE_MSB:0], 10'(TIMEOUT)};
  assign wait_done = 1'b1;
  assign mon_score = '0;
  assign mon_err   = '0;
`endif

  // state, phase counter and latched pattern
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      pat_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) pat_q <= pat_data;
    end
  end

  // next-state and phase counter
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE:   if (accept) begin state_d = ST_COLOR; cnt_d = '0; end
      ST_COLOR:  if (cnt_q == 6'(N_CELLS - 1)) begin state_d = ST_GAP; cnt_d = '0; end
                 else cnt_d = cnt_q + 6'd1;
      ST_GAP:    if (cnt_q == 6'(GAP_CYCLES - 1)) begin state_d = ST_ACTION; cnt_d = '0; end
                 else cnt_d = cnt_q + 6'd1;
      ST_ACTION: if (cnt_q == 6'(N_ACTIONS - 1)) begin
`ifdef CC_PATTERN_TX_CHECK_EN
                   state_d = ST_WAIT;
`else
                   state_d = ST_REPORT;
`endif
                   cnt_d = '0;
                 end else cnt_d = cnt_q + 6'd1;
      ST_WAIT:   if (wait_done) state_d = ST_REPORT;
      ST_REPORT: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // stream data for the upcoming cycle; everything is 0 outside its strobe
  always_comb begin
    i        = int'(cnt_d);
    v1_d     = (state_d == ST_COLOR);
    v2_d     = (state_d == ST_ACTION);
    rv_d     = (state_d == ST_REPORT);
    color_d  = '0;
    pos_d    = '0;
    stripe_d = 1'b0;
    act_d    = '0;
    t3       = '0;
    if (v1_d) begin
      color_d = fld3(pat_src, COLOR_MSB - 2 - 3 * i);
      if (i < N_STRIPES) begin
        pos_d    = {fld3(pat_src, SROW_MSB - 2 - 3 * i), fld3(pat_src, SCOL_MSB - 2 - 3 * i)};
        t3       = fld3(pat_src, STYPE_MSB - i);
        stripe_d = t3[0];
      end
    end else if (v2_d) begin
      pos_d = {fld3(pat_src, AROW_MSB - 2 - 3 * i), fld3(pat_src, ACOL_MSB - 2 - 3 * i)};
      t3    = fld3(pat_src, ACT_MSB - 1 - 2 * i);
      act_d = t3[1:0];
    end
  end

  // registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pat_ready       <= 1'b1;
      in_valid_1      <= 1'b0;
      in_valid_2      <= 1'b0;
      in_color        <= '0;
      in_starting_pos <= '0;
      in_stripe       <= 1'b0;
      in_action       <= '0;
      result_valid    <= 1'b0;
      result_score    <= '0;
      result_err      <= '0;
      result_pass     <= 1'b0;
    end else begin
      pat_ready       <= (state_d == ST_IDLE);
      in_valid_1      <= v1_d;
      in_valid_2      <= v2_d;
      in_color        <= color_d;
      in_starting_pos <= pos_d;
      in_stripe       <= stripe_d;
      in_action       <= act_d;
      result_valid    <= rv_d;
      result_score    <= rv_d ? mon_score : '0;
      result_err      <= rv_d ? mon_err : '0;
      result_pass     <= rv_d && (mon_err == '0);
    end
  end

endmodule

// File: tb/tb_cc_pattern_tx.sv
// Directed bench for cc_pattern_tx: stream shape, result timing, reset abort.
module tb_cc_pattern_tx;

  localparam int GAP = 1;
  localparam int TMO = 500;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         pat_valid = 1'b0;
  logic         pat_ready;
  logic [222:0] pat_data = '0;
  logic         in_valid_1, in_valid_2, in_stripe;
  logic [2:0]   in_color;
  logic [5:0]   in_starting_pos;
  logic [1:0]   in_action;
  logic         out_valid = 1'b0;
  logic [6:0]   out_score = '0;
  logic         result_valid, result_pass;
  logic [6:0]   result_score;
  logic [3:0]   result_err;

  cc_pattern_tx #(.GAP_CYCLES(GAP), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .pat_valid(pat_valid), .pat_ready(pat_ready), .pat_data(pat_data),
    .in_valid_1(in_valid_1), .in_valid_2(in_valid_2), .in_color(in_color),
    .in_starting_pos(in_starting_pos), .in_stripe(in_stripe), .in_action(in_action),
    .out_valid(out_valid), .out_score(out_score), .result_valid(result_valid),
    .result_score(result_score), .result_err(result_err), .result_pass(result_pass)
  );

  always #5 clk = ~clk;

  int n_run  = 0;
  int n_fail = 0;

  logic [2:0]   colors[36];
  logic [2:0]   srow[4], scol[4];
  logic         styp[4];
  logic [2:0]   arow[10], acol[10];
  logic [1:0]   act[10];
  logic [6:0]   exps;
  logic [222:0] pat;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_run++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // fill the field tables for pattern k and pack them into pat
  task automatic make_pat(input int k, input logic [6:0] score);
    for (int c = 0; c < 36; c++) colors[c] = 3'((c * 3 + k * 5 + 1) % 8);
    for (int j = 0; j < 4; j++) begin
      srow[j] = 3'(j + k + 1);
      scol[j] = 3'(6 - j + k);
      styp[j] = 1'((j + k) % 2);
    end
    for (int a = 0; a < 10; a++) begin
      arow[a] = 3'(a + k);
      acol[a] = 3'(9 - a);
      act[a]  = 2'((a + k) % 4);
    end
    exps = score;
    pat  = '0;
    for (int c = 0; c < 36; c++) pat |= 223'(colors[c]) << (220 - 3 * c);
    for (int j = 0; j < 4; j++) begin
      pat |= 223'(srow[j]) << (112 - 3 * j);
      pat |= 223'(scol[j]) << (100 - 3 * j);
      pat |= 223'(styp[j]) << (90 - j);
    end
    for (int a = 0; a < 10; a++) begin
      pat |= 223'(arow[a]) << (84 - 3 * a);
      pat |= 223'(acol[a]) << (54 - 3 * a);
      pat |= 223'(act[a])  << (25 - 2 * a);
    end
    pat |= 223'(exps);
  endtask

  task automatic chk_idle_outs(input string tag);
    chk({tag, " ready"}, pat_ready, 1);
    chk({tag, " streams"}, {in_valid_1, in_valid_2, in_color, in_starting_pos, in_stripe, in_action}, 0);
    chk({tag, " result"}, {result_valid, result_score, result_err, result_pass}, 0);
  endtask

  // resp: WAIT cycle of the stub response (-1 none); noise: out_valid pulses in color cycles 3,4
  task automatic run_pattern(input int resp, input logic [6:0] rscore, input bit noise, input int abort_cyc);
    int rv_cyc, resp_cyc, c, a;
    logic ev1, ev2, estr;
    logic [2:0] ecol;
    logic [5:0] epos;
    logic [1:0] eact;
    logic [6:0] escore;
    logic [3:0] eerr;
    resp_cyc = (resp >= 0) ? 47 + GAP + resp : -100;
`ifdef CC_PATTERN_TX_CHECK_EN
    rv_cyc = (resp >= 0) ? 47 + GAP + resp + 1 : 47 + GAP + TMO;
    escore = (resp >= 0) ? rscore : 7'd0;
    eerr   = {noise, noise, resp < 0, (resp >= 0) && (rscore != exps)};
`else
    rv_cyc = 47 + GAP;
    escore = '0;
    eerr   = '0;
`endif
    @(negedge clk);
    chk("pre ready", pat_ready, 1);
    pat_data  = pat;
    pat_valid = 1'b1;
    @(posedge clk);
    for (int cyc = 1; cyc <= rv_cyc + 1; cyc++) begin
      @(negedge clk);
      c = cyc - 1;
      a = cyc - 37 - GAP;
      ev1 = (cyc >= 1) && (cyc <= 36);
      ev2 = (a >= 0) && (a < 10);
      ecol = ev1 ? colors[c] : 3'd0;
      estr = (ev1 && c < 4) ? styp[c] : 1'b0;
      epos = (ev1 && c < 4) ? {srow[c], scol[c]} : ev2 ? {arow[a], acol[a]} : 6'd0;
      eact = ev2 ? act[a] : 2'd0;
      chk($sformatf("c%0d v1", cyc), in_valid_1, ev1);
      chk($sformatf("c%0d v2", cyc), in_valid_2, ev2);
      chk($sformatf("c%0d color", cyc), in_color, ecol);
      chk($sformatf("c%0d pos", cyc), in_starting_pos, epos);
      chk($sformatf("c%0d stripe", cyc), in_stripe, estr);
      chk($sformatf("c%0d action", cyc), in_action, eact);
      chk($sformatf("c%0d ready", cyc), pat_ready, cyc > rv_cyc);
      chk($sformatf("c%0d rvalid", cyc), result_valid, cyc == rv_cyc);
      chk($sformatf("c%0d rscore", cyc), result_score, (cyc == rv_cyc) ? escore : 7'd0);
      chk($sformatf("c%0d rerr", cyc), result_err, (cyc == rv_cyc) ? eerr : 4'd0);
      chk($sformatf("c%0d rpass", cyc), result_pass, (cyc == rv_cyc) && (eerr == 0));
      // latched pattern must not follow the bus after accept
      pat_data = ~pat;
      out_valid = (cyc == resp_cyc) || (noise && (cyc == 3 || cyc == 4));
      out_score = (cyc == resp_cyc) ? rscore : (out_valid ? 7'd5 : 7'd0);
      if (cyc == abort_cyc) begin
        rst_n = 1'b0;
        #1;
        chk_idle_outs("abort");
        repeat (3) begin
          @(negedge clk);
          chk_idle_outs("in reset");
        end
        pat_valid = 1'b0;
        out_valid = 1'b0;
        out_score = '0;
        rst_n     = 1'b1;
        return;
      end
      if (cyc == rv_cyc + 1) begin
        pat_valid = 1'b0;
        out_valid = 1'b0;
        out_score = '0;
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    chk_idle_outs("reset");
    rst_n = 1'b1;
    @(negedge clk);
    chk_idle_outs("post reset");

    make_pat(0, 7'd42); run_pattern(5, 7'd42, 1'b0, -1);   // matching response
    make_pat(1, 7'd41); run_pattern(5, 7'd42, 1'b0, -1);   // score mismatch
    make_pat(2, 7'd42); run_pattern(-1, 7'd0, 1'b0, -1);   // no response
    make_pat(3, 7'd42); run_pattern(5, 7'd42, 1'b1, -1);   // out_valid during COLOR, two cycles
    make_pat(4, 7'd42); run_pattern(5, 7'd42, 1'b1, 37 + GAP + 3); // reset in ACTION cycle 3
    make_pat(5, 7'd42); run_pattern(5, 7'd42, 1'b0, -1);   // clean run after abort

    @(negedge clk);
    chk_idle_outs("end");
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
